// File: rtl/sync_data_memory.sv
// Byte-addressed data memory with b/h/w access; loads and misalign flags appear one cycle after the request edge.
// Ready stays low during the post-reset clear sweep; requests presented while Ready is low are dropped.
module sync_data_memory #(
    parameter int ADDR_WIDTH     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        Ready,
    output logic        Misaligned
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clearPtr;
    logic [31:0]             mem [DEPTH];
    logic [31:0]             memQ;

    logic [ADDR_WIDTH-1:0]   wordIdx;
    logic                    unusedAddrBits;
    logic                    misalign;
    logic                    accept;
    logic                    isStore;
    logic                    isLoad;
    logic                    badReq;
    logic [3:0]              byteEn;
    logic [31:0]             wrData;

    logic                    ldPend;
    logic                    badPend;
    logic [1:0]              ldLane;
    logic [1:0]              ldSize;
    logic                    ldUns;
    logic [7:0]              ldByte;
    logic [15:0]             ldHalf;
    logic [31:0]             loadExt;

    // Upper address bits are deliberately ignored so addresses wrap modulo DEPTH words.
    assign wordIdx        = Address[ADDR_WIDTH+1:2];
    assign unusedAddrBits = ^Address[31:ADDR_WIDTH+2];

    always_comb begin
        misalign = 1'b0;
        byteEn   = 4'b0000;
        wrData   = WriteData;
        case (Size)
            2'b00: begin
                byteEn = 4'b0001 << Address[1:0];
                wrData = {4{WriteData[7:0]}};
            end
            2'b01: begin
                misalign = Address[0];
                byteEn   = Address[1] ? 4'b1100 : 4'b0011;
                wrData   = {2{WriteData[15:0]}};
            end
            2'b10: begin
                misalign = (Address[1:0] != 2'b00);
                byteEn   = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
    end

    assign accept  = Ready & (MemRead | MemWrite);
    assign isStore = accept & MemWrite & ~misalign;
    assign isLoad  = accept & MemRead & ~MemWrite & ~misalign;
    assign badReq  = accept & misalign;

    // Storage has no reset of its own; zeroing is done by the sweep.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state == CLEAR) begin
                mem[clearPtr] <= '0;
            end else if (isStore) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteEn[b]) mem[wordIdx][b*8 +: 8] <= wrData[b*8 +: 8];
                end
            end
            memQ <= mem[wordIdx];
        end
    end

    always_comb begin
        ldByte = memQ[7:0];
        case (ldLane)
            2'd0: ldByte = memQ[7:0];
            2'd1: ldByte = memQ[15:8];
            2'd2: ldByte = memQ[23:16];
            2'd3: ldByte = memQ[31:24];
            default: ldByte = memQ[7:0];
        endcase
        ldHalf = ldLane[1] ? memQ[31:16] : memQ[15:0];
        case (ldSize)
            2'b00:   loadExt = {{24{~ldUns & ldByte[7]}}, ldByte};
            2'b01:   loadExt = {{16{~ldUns & ldHalf[15]}}, ldHalf};
            default: loadExt = memQ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clearPtr   <= '0;
            Ready      <= 1'b0;
            ldPend     <= 1'b0;
            badPend    <= 1'b0;
            ldLane     <= 2'b00;
            ldSize     <= 2'b00;
            ldUns      <= 1'b0;
            ReadData   <= '0;
            ReadValid  <= 1'b0;
            Misaligned <= 1'b0;
        end else begin
            ReadValid  <= ldPend;
            Misaligned <= badPend;
            if (ldPend) ReadData <= loadExt;
            ldPend  <= isLoad;
            badPend <= badReq;
            ldLane  <= Address[1:0];
            ldSize  <= Size;
            ldUns   <= Unsigned;
            case (state)
                CLEAR: begin
                    clearPtr <= clearPtr + 1'b1;
                    if (clearPtr == '1) begin
                        state <= IDLE;
                        Ready <= 1'b1;
                    end
                end
                default: Ready <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_sync_data_memory.sv
// Directed bench for sync_data_memory: sweep, sub-word access, misalignment, wrap, pipelining, reset.
module tb_sync_data_memory;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        Ready;
    logic        Misaligned;

    int nAssert = 0;
    int nFail   = 0;

    sync_data_memory dut (
        .Clk(Clk), .Reset(Reset), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size), .Unsigned(Unsigned),
        .ReadData(ReadData), .ReadValid(ReadValid), .Ready(Ready), .Misaligned(Misaligned)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data);
        MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns; Address = addr; WriteData = data;
        tick();
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
        req(1'b0, 1'b1, sz, 1'b0, addr, data);
    endtask

    task automatic ldchk(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp);
        req(1'b1, 1'b0, sz, uns, addr, 32'h0);
        tick();
        chk({tag, "_valid"}, {31'b0, ReadValid}, 32'd1);
        chk({tag, "_data"}, ReadData, exp);
        chk({tag, "_nomis"}, {31'b0, Misaligned}, 32'd0);
        tick();
        chk({tag, "_pulse"}, {31'b0, ReadValid}, 32'd0);
    endtask

    task automatic misreq(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] data, input logic [31:0] heldData);
        req(rd, wr, sz, 1'b0, addr, data);
        tick();
        chk({tag, "_mis"}, {31'b0, Misaligned}, 32'd1);
        chk({tag, "_novalid"}, {31'b0, ReadValid}, 32'd0);
        chk({tag, "_hold"}, ReadData, heldData);
        tick();
        chk({tag, "_mispulse"}, {31'b0, Misaligned}, 32'd0);
    endtask

    initial begin
        int cnt;
        int pulses;
        Reset = 1'b1; Address = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0;
        Size = 2'b10; Unsigned = 1'b0;

        // 1. reset and sweep length
        tick(); tick();
        chk("rst_ready", {31'b0, Ready}, 32'd0);
        chk("rst_rdata", ReadData, 32'h0);
        chk("rst_rvalid", {31'b0, ReadValid}, 32'd0);
        chk("rst_mis", {31'b0, Misaligned}, 32'd0);
        Reset = 1'b0;
        cnt = 0;
        while (!Ready && cnt < 2000) begin
            tick();
            cnt++;
        end
        chk("sweep_len", cnt, 32'd1024);
        ldchk("lw_3fc", 2'b10, 1'b0, 32'h3FC, 32'h0);

        // 2. sub-word stores and loads
        store(2'b10, 32'h10, 32'h11223344);
        store(2'b00, 32'h11, 32'h000000AA);
        ldchk("lw_10", 2'b10, 1'b0, 32'h10, 32'h1122AA44);
        ldchk("lb_11", 2'b00, 1'b0, 32'h11, 32'hFFFFFFAA);
        ldchk("lbu_11", 2'b00, 1'b1, 32'h11, 32'h000000AA);
        ldchk("lh_12", 2'b01, 1'b0, 32'h12, 32'h00001122);
        ldchk("lh_10", 2'b01, 1'b0, 32'h10, 32'hFFFFAA44);
        ldchk("lhu_10", 2'b01, 1'b1, 32'h10, 32'h0000AA44);
        ldchk("lb_13", 2'b00, 1'b0, 32'h13, 32'h00000011);
        store(2'b01, 32'h16, 32'h0000BEEF);
        ldchk("sh_16", 2'b10, 1'b0, 32'h14, 32'hBEEF0000);

        // 3. misalignment (ReadData must keep the last load value)
        misreq("sw_22", 1'b0, 1'b1, 2'b10, 32'h22, 32'hDEADBEEF, 32'hBEEF0000);
        misreq("lh_21", 1'b1, 1'b0, 2'b01, 32'h21, 32'h0, 32'hBEEF0000);
        misreq("sz11_20", 1'b0, 1'b1, 2'b11, 32'h20, 32'hDEADBEEF, 32'hBEEF0000);
        ldchk("lw_20", 2'b10, 1'b0, 32'h20, 32'h0);

        // 4. address wrap
        store(2'b10, 32'h00001000, 32'hCAFEF00D);
        ldchk("wrap_0", 2'b10, 1'b0, 32'h0, 32'hCAFEF00D);

        // 5. back-to-back loads, then simultaneous read+write
        store(2'b10, 32'h14, 32'h55667788);
        MemRead = 1'b1; MemWrite = 1'b0; Size = 2'b10; Address = 32'h10;
        tick();
        chk("b2b_lat", {31'b0, ReadValid}, 32'd0);
        Address = 32'h14;
        tick();
        chk("b2b_v0", {31'b0, ReadValid}, 32'd1);
        chk("b2b_d0", ReadData, 32'h1122AA44);
        Address = 32'h10;
        tick();
        chk("b2b_v1", {31'b0, ReadValid}, 32'd1);
        chk("b2b_d1", ReadData, 32'h55667788);
        MemRead = 1'b0;
        tick();
        chk("b2b_v2", {31'b0, ReadValid}, 32'd1);
        chk("b2b_d2", ReadData, 32'h1122AA44);
        tick();
        chk("b2b_end", {31'b0, ReadValid}, 32'd0);

        req(1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'h5);
        chk("rw_novalid0", {31'b0, ReadValid}, 32'd0);
        tick();
        chk("rw_novalid1", {31'b0, ReadValid}, 32'd0);
        ldchk("rw_stored", 2'b10, 1'b0, 32'h14, 32'h5);

        // reset in the cycle after an accepted load cancels its response
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        Reset = 1'b1;
        tick();
        chk("cancel_valid", {31'b0, ReadValid}, 32'd0);
        chk("cancel_data", ReadData, 32'h0);
        chk("cancel_ready", {31'b0, Ready}, 32'd0);
        Reset = 1'b0;

        // 6. reset mid-sweep, with requests during the sweep
        pulses = 0;
        for (int i = 0; i < 499; i++) begin
            tick();
            pulses += int'(ReadValid) + int'(Misaligned) + int'(Ready);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mid_ready", {31'b0, Ready}, 32'd0);
        cnt = 0;
        while (!Ready && cnt < 2000) begin
            if (cnt == 600) begin
                MemWrite = 1'b1; Size = 2'b10; Address = 32'h3FC; WriteData = 32'hFFFFFFFF;
            end else if (cnt == 601) begin
                MemWrite = 1'b0; MemRead = 1'b1; Size = 2'b01; Address = 32'h21;
            end else if (cnt == 602) begin
                Size = 2'b10; Address = 32'h14;
            end else begin
                MemRead = 1'b0; MemWrite = 1'b0;
            end
            tick();
            cnt++;
            if (!Ready) pulses += int'(ReadValid) + int'(Misaligned);
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        chk("mid_sweep_len", cnt, 32'd1024);
        chk("mid_no_pulses", pulses, 32'd0);
        ldchk("mid_nowrite", 2'b10, 1'b0, 32'h3FC, 32'h0);
        ldchk("mid_cleared", 2'b10, 1'b0, 32'h10, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
